encoder_job_arbiter: RTL and testbench
======================================

# encoder_job_arbiter

Shares one encoder core (the round-sequenced datapath/controller pair driven by a start pulse and answering with a ready level) between two independent requesters. Arbitrates round-robin, launches the core with a one-cycle start pulse, and waits for completion under a watchdog. Returns a done pulse to the winning requester and keeps a completed-job count. Sits between the system-level requesters and the encoder core's `start`/`ready` pins.

## Interface
- `TIMEOUT`, 64: maximum WAIT cycles allowed before the job is aborted (≥2).
- `CNT_W`, 8: width of `job_count`.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1 each  job request; held high by requester until its `done` pulse.
- `core_ready`  in  1  encoder core completion level.
- `gnt0`, `gnt1`  out  1 each  grant, held for the whole job; one-hot or zero.
- `done0`, `done1`  out  1 each  one-cycle job-finished pulse to granted requester.
- `core_start`  out  1  one-cycle start pulse to encoder core.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky watchdog error flag.
- `job_count`  out  CNT_W  successfully completed jobs, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, GRANT, START, WAIT, DONE. Reset → IDLE.
- IDLE: if neither req high, stay. Otherwise select winner, → GRANT.
- Selection: one req high → it wins. Both high → the one not equal to `last_served` wins. `last_served` resets to 1 (req0 wins first tie).
- GRANT: assert winner's gnt (held through GRANT, START, WAIT, DONE); → START.
- START: `core_start`=1 for exactly this cycle; clear watchdog; → WAIT. `core_ready` ignored in GRANT and START.
- WAIT: if `core_ready`=1 → DONE (success). Else increment watchdog; if this is the TIMEOUT-th WAIT cycle with `core_ready` low → DONE (timeout), set `timeout_err`.
- DONE: pulse winner's done; `last_served` ← winner; `job_count` += 1 on success only; → IDLE. Gnt drops on leaving DONE.
- Requester dropping req mid-job: ignored; job completes, done still pulses.
- New req arriving while busy: waits; evaluated in next IDLE.
- `timeout_err` cleared only by `rst`; subsequent jobs proceed normally.
- `job_count` wraps from 2^CNT_W−1 to 0, no flag.
- Watchdog width ⌈log2(TIMEOUT+1)⌉, never wraps (capped by transition).
- Reset mid-operation: all outputs return to reset values next edge, FSM → IDLE, in-flight job abandoned, no done pulse.

## Timing
- Reset values: gnt0/gnt1/done0/done1/core_start/busy/timeout_err = 0, job_count = 0.
- All outputs registered (Moore, from state/winner registers).
- Req high sampled in IDLE at edge t: gnt and busy high from t+1, `core_start` high in cycle t+2 only, WAIT from t+3.
- `core_ready` sampled high at WAIT edge k: done pulse in cycle k+1, job_count updated visible at k+2, IDLE at k+2, next gnt earliest k+3.
- Minimum job turnaround (core_ready already high entering WAIT): 5 cycles req→IDLE.
- Timeout: WAIT entered at edge w, no ready → `timeout_err` and done visible at w+TIMEOUT.
- `core_ready` and timeout on the same WAIT cycle: success wins, no error.

## Test plan
- Reset, req0 high alone, core_ready asserted 10 cycles after core_start → gnt0 1 cycle after req, single core_start pulse, done0 one pulse, job_count=1, gnt1/done1 never high.
- req0 and req1 high together from reset, core_ready after 3 cycles each → serve req0 then req1 then req0 alternately; 6 jobs → job_count=6, three done0 and three done1 pulses.
- TIMEOUT=8, core_ready never asserted → done0 at 8 cycles after WAIT entry, timeout_err=1 sticky, job_count=0; next job with ready succeeds, job_count=1, timeout_err stays 1.
- core_ready held high continuously, req1 held → back-to-back 5-cycle jobs, core_start pulses exactly once per job; core_ready during GRANT/START does not skip START.
- rst asserted during WAIT → next cycle all outputs 0, state IDLE, no done pulse; req0 after reset served normally, req0 wins tie.
- CNT_W=2, 5 successful jobs → job_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/encoder_job_arbiter.sv
// Round-robin arbiter sharing one encoder core between two requesters.
// Launches the core with a start pulse, waits for ready under a watchdog, and counts successful jobs.
`timescale 1ns/1ps
module encoder_job_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             core_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             core_start,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] job_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             winner_q, winner_d;
  logic             last_q, last_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    ok_d     = ok_q;
    err_d    = err_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        // On a tie, whoever was not served last goes next.
        if (req0 || req1) begin
          winner_d = (req0 && req1) ? ~last_q : req1;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: state_d = S_START;
      S_START: begin
        wd_d    = '0;
        ok_d    = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ready is checked before the watchdog so a late-but-valid completion still counts.
        if (core_ready) begin
          ok_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        last_d  = winner_q;
        state_d = S_IDLE;
        if (ok_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign gnt0        = busy && !winner_q;
  assign gnt1        = busy && winner_q;
  assign core_start  = (state_q == S_START);
  assign done0       = (state_q == S_DONE) && !winner_q;
  assign done1       = (state_q == S_DONE) && winner_q;
  assign timeout_err = err_q;
  assign job_count   = cnt_q;

endmodule

// File: tb/tb_encoder_job_arbiter.sv
// Randomized bench for encoder_job_arbiter against a job-timeline reference model.
// Requesters and the core responder are driven from the model's expectations.
`timescale 1ns/1ps
module tb_encoder_job_arbiter;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 2;
  localparam int NCYC    = 4000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic             core_ready = 1'b0;
  logic             gnt0, gnt1, done0, done1, core_start, busy, timeout_err;
  logic [CNT_W-1:0] job_count;

  int checks = 0;
  int errors = 0;

  // Reference model: a job is described by its winner and its age in cycles since grant.
  bit m_active = 1'b0;
  bit m_win    = 1'b0;
  bit m_last   = 1'b1;
  bit m_fin    = 1'b0;
  bit m_ok     = 1'b0;
  bit m_err    = 1'b0;
  int m_age    = 0;
  int m_cnt    = 0;

  int  rc = -1;
  int  done_seen = 0;
  int  done_model = 0;
  int  n_timeouts = 0;
  bit  always_hi = 1'b0;
  bit  hold_both = 1'b0;
  bit  waiting;
  bit  r [2];
  bit  dn [2];

  always #5 clk = ~clk;

  encoder_job_arbiter #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .core_ready (core_ready),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .core_start (core_start),
    .busy       (busy),
    .timeout_err(timeout_err),
    .job_count  (job_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_step();
    if (rst) begin
      m_active = 1'b0;
      m_fin    = 1'b0;
      m_last   = 1'b1;
      m_err    = 1'b0;
      m_cnt    = 0;
    end else if (!m_active) begin
      if (req0 || req1) begin
        m_active = 1'b1;
        m_win    = (req0 && req1) ? !m_last : req1;
        m_age    = 0;
        m_fin    = 1'b0;
        m_ok     = 1'b0;
      end
    end else if (m_fin) begin
      m_active = 1'b0;
      m_last   = m_win;
      if (m_ok) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else begin
      // Ages 0 and 1 are grant and start; from age 2 on, each cycle is one wait cycle.
      if (m_age >= 2) begin
        if (core_ready) begin
          m_fin = 1'b1;
          m_ok  = 1'b1;
        end else if (m_age - 1 == TIMEOUT) begin
          m_fin = 1'b1;
          m_err = 1'b1;
        end
      end
      m_age++;
    end
  endtask

  function automatic logic [6:0] exp_outs();
    logic d;
    d = m_active && m_fin;
    return {m_active && !m_win, m_active && m_win, d && !m_win, d && m_win,
            m_active && !m_fin && (m_age == 1), m_active, m_err};
  endfunction

  initial begin
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      model_step();
      @(posedge clk);
      #1;
      check_eq("outputs{g0,g1,d0,d1,start,busy,err}",
               {gnt0, gnt1, done0, done1, core_start, busy, timeout_err}, exp_outs());
      check_eq("job_count", job_count, m_cnt);
      if (done0 || done1) done_seen++;
      if (m_active && m_fin) begin
        done_model++;
        if (!m_ok) n_timeouts++;
        $display("job %0d: requester %0d %s, job_count=%0d, timeout_err=%0d",
                 done_model, m_win, m_ok ? "completed" : "timed out", m_cnt, m_err);
      end

      hold_both = (cyc >= 2500 && cyc < 3000);
      always_hi = (cyc >= 3000 && cyc < 3300);
      rst = (cyc < 2) || (cyc > 10 && $urandom_range(0, 399) == 0);

      dn[0] = m_active && m_fin && !m_win;
      dn[1] = m_active && m_fin && m_win;
      r[0]  = req0;
      r[1]  = req1;
      for (int i = 0; i < 2; i++) begin
        if (dn[i]) r[i] = 1'b0;
        else if (!r[i] && $urandom_range(0, 3) == 0) r[i] = 1'b1;
        else if (r[i] && $urandom_range(0, 40) == 0) r[i] = 1'b0;
      end
      if (hold_both) begin
        r[0] = 1'b1;
        r[1] = 1'b1;
      end
      if (always_hi) begin
        r[0] = 1'b0;
        r[1] = 1'b1;
      end
      req0 = r[0];
      req1 = r[1];

      // Core responder: ready rises a random number of wait cycles after start and holds until done.
      if ((m_active && m_fin) || rst) rc = -1;
      if (m_active && !m_fin && m_age == 1) rc = $urandom_range(0, TIMEOUT + 3);
      waiting = m_active && !m_fin && (m_age >= 2);
      core_ready = always_hi || (rc == 0) || (!waiting && $urandom_range(0, 3) == 0);
      if (rc > 0) rc--;
    end
    rst = 1'b0;
    check_eq("done_pulse_total", done_seen, done_model);
    $display("info: %0d jobs finished, %0d by watchdog", done_model, n_timeouts);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
